tff_bank_arbiter: RTL and testbench

TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

---
 rtl/tff_bank_arbiter_if.sv | 16 +
 rtl/tff_bank_arbiter.sv | 173 +++++++++++++++++
 tb/tb_tff_bank_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tff_bank_arbiter_if.sv
// Request/grant/bank bus for tff_bank_arbiter: the master drives requests, masks
// and clear, and the slave returns the grant, done pulse, bank state and busy.
interface tff_bank_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] mask;
  logic               clr;
  logic [3:0]         gnt;
  logic               done;
  logic [WIDTH-1:0]   q;
  logic               busy;

  modport master (output req, mask, clr, input gnt, done, q, busy);
  modport slave  (input req, mask, clr, output gnt, done, q, busy);
endinterface

// File: rtl/tff_bank_arbiter.sv
// Four-requester arbiter sharing one bank of WIDTH T flip-flops.
// Define TFF_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); round-robin otherwise.
module tff_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tff_bank_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    APPLY   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        win_q, win_d;
  logic [1:0]        win_sel;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  mask_sel;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  bank_q, bank_d;

`ifdef TFF_ARB_FIXED_PRIO_EN
  function automatic logic [1:0] pick_winner(input logic [3:0] r);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) begin
        res = k[1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`else
  logic [1:0] ptr_q, ptr_d;

  // Search starts at the pointer; the 2-bit sum wraps 3 -> 0 on its own.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + k[1:0];
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction
`endif

  // Winner candidate and its mask, evaluated every cycle for use from IDLE
  always_comb begin
`ifdef TFF_ARB_FIXED_PRIO_EN
    win_sel = pick_winner(bus.req);
`else
    win_sel = pick_winner(bus.req, ptr_q);
`endif
    mask_sel = bus.mask[int'(win_sel)*WIDTH +: WIDTH];
  end

  // Next-state and output logic of the grant sequencer
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    bank_d  = bank_q;
`ifndef TFF_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          win_d   = win_sel;
          mask_d  = mask_sel;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_sel;
        end else begin
          gnt_d   = {NREQ{1'b0}};
        end
      end
      GRANT: begin
        if (bus.req[win_q]) begin
          state_d = APPLY;
          bank_d  = bank_q ^ mask_q;
          done_d  = 1'b1;
`ifndef TFF_ARB_FIXED_PRIO_EN
          ptr_d   = win_q + 2'd1;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = {NREQ{1'b0}};
        end
      end
      APPLY: begin
        state_d = RELEASE;
        // Requester already let go after seeing done: drop the grant now
        if (!bus.req[win_q]) begin
          gnt_d = {NREQ{1'b0}};
        end else begin
          gnt_d = gnt_q;
        end
      end
      RELEASE: begin
        if (!bus.req[win_q] || (gnt_q == {NREQ{1'b0}})) begin
          state_d = IDLE;
          gnt_d   = {NREQ{1'b0}};
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
    endcase
    // Clear wins over a coincident toggle; sequencing is untouched
    if (bus.clr) begin
      bank_d = {WIDTH{1'b0}};
    end else begin
      bank_d = bank_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      mask_q  <= {WIDTH{1'b0}};
      gnt_q   <= {NREQ{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      bank_q  <= {WIDTH{1'b0}};
`ifndef TFF_ARB_FIXED_PRIO_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
`ifndef TFF_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.q    = bank_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Scoreboard bench for tff_bank_arbiter: transaction-level reference model,
// directed scenarios followed by randomized request sets.
module tb_tff_bank_arbiter;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  tff_bank_arbiter_if #(.WIDTH(WIDTH)) bus ();

  tff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]       gnt;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [WIDTH-1:0] mask_v[4];
  logic [WIDTH-1:0] m_q;
  int               m_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r);
`ifdef TFF_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic drive_masks();
    for (int i = 0; i < 4; i++) bus.mask[i*WIDTH +: WIDTH] = mask_v[i];
  endtask

  // Monitor: every done pulse must match the oldest expected transaction
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_q", int'(bus.q), int'(e.q));
        check("done_gnt", int'(bus.gnt), int'(e.gnt));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(bus.busy), 0);
  endtask

  // Serve every requester in pend, each holding req until done (or aborting)
  task automatic run_set(input logic [3:0] pend_in, input bit abort_first, input bit clr_first);
    logic [3:0]       pend;
    logic [WIDTH-1:0] lm;
    logic [3:0]       onehot;
    bit               first;
    int               w;
    int               n;
    exp_t             e;
    pend  = pend_in;
    first = 1'b1;
    wait_idle();
    drive_masks();
    bus.req = pend;
    while (pend != 4'b0000) begin
      w = model_pick(pend);
      onehot = 4'b0001 << w;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.gnt == 4'b0000 && n < 20);
      check("gnt_winner", int'(bus.gnt), int'(onehot));
      if (first) check("grant_latency", n, 1);
      lm = mask_v[w];
      mask_v[w] = ~lm;
      drive_masks();
      if (first && abort_first) begin
        bus.req[w] = 1'b0;
        pend[w] = 1'b0;
        @(negedge clk);
        check("abort_gnt", int'(bus.gnt), 0);
        check("abort_no_done", int'(bus.done), 0);
        check("abort_q", int'(bus.q), int'(m_q));
      end else begin
        bus.clr = first && clr_first;
        m_q = (first && clr_first) ? {WIDTH{1'b0}} : (m_q ^ lm);
        m_ptr = (w + 1) % 4;
        e.gnt = onehot;
        e.q = m_q;
        sb.push_back(e);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.done && n < 20);
        check("done_seen", int'(bus.done), 1);
        bus.clr = 1'b0;
        bus.req[w] = 1'b0;
        pend[w] = 1'b0;
        @(negedge clk);
        check("gnt_release", int'(bus.gnt), 0);
      end
      first = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, int'(bus.gnt), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_q"}, int'(bus.q), 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.clr = 1'b0;
    for (int i = 0; i < 4; i++) mask_v[i] = {WIDTH{1'b0}};
    drive_masks();
    m_q = {WIDTH{1'b0}};
    m_ptr = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single request, mask 1010
    mask_v[0] = 4'b1010;
    run_set(4'b0001, 1'b0, 1'b0);
    check("single_q", int'(bus.q), 10);

    // All four at once with mask 0001 each
    for (int i = 0; i < 4; i++) mask_v[i] = 4'b0001;
    run_set(4'b1111, 1'b0, 1'b0);

    // Latched mask 0011 used although the mask changes after grant
    mask_v[1] = 4'b0011;
    run_set(4'b0010, 1'b0, 1'b0);

    // Abort, then all four: pointer must not have moved
    mask_v[2] = 4'b0110;
    run_set(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) mask_v[i] = 4'(i + 5);
    run_set(4'b1111, 1'b0, 1'b0);

    // Clear coinciding with the toggle
    mask_v[0] = 4'b0110;
    run_set(4'b0001, 1'b0, 1'b1);
    check("clr_apply_q", int'(bus.q), 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) mask_v[i] = WIDTH'($urandom);
      run_set(4'($urandom_range(1, 15)), ($urandom % 6) == 0, ($urandom % 5) == 0);
    end

    // Reset while the toggle is showing
    wait_idle();
    mask_v[3] = 4'b1001;
    drive_masks();
    bus.req = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 4'b0000 && n < 20);
    check("rst_test_gnt", int'(bus.gnt), 8);
    m_q = m_q ^ mask_v[3];
    e.gnt = 4'b1000;
    e.q = m_q;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    check("rst_test_done", int'(bus.done), 1);
    #2 rst_n = 1'b0;
    bus.req = 4'b0000;
    #1 check_reset_outputs("midreset");
    m_q = {WIDTH{1'b0}};
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_q", int'(bus.q), 0);

    mask_v[2] = 4'b0101;
    run_set(4'b0100, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
